// File: rtl/fadder_seq.sv
`default_nettype none
// ============================================================================
// Module   : fadder_seq
// Purpose  : Command FIFO and load/execute sequencer in front of the full
//            adder/subtractor, returning each registered result over valid/ready.
// Revision : 1.0
// ============================================================================
module fadder_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_op_a,
    input  logic [DATA_WIDTH-1:0] cmd_op_b,
    input  logic                  cmd_carry_in,
    output logic                  add_vld_in,
    output logic                  add_ex,
    output logic                  add_op,
    output logic [DATA_WIDTH-1:0] add_op_a,
    output logic [DATA_WIDTH-1:0] add_op_b,
    output logic                  add_carry_in,
    input  logic [DATA_WIDTH-1:0] add_data_out,
    input  logic                  add_carry_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_carry,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  ops_done
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    typedef struct packed {
        logic                  op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  cin;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_CAPT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    cmd_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    state_t             state;
    cmd_t               cur_cmd;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full      = (count == COUNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign busy      = (state != S_IDLE) || !empty;

    assign add_op_a     = cur_cmd.a;
    assign add_op_b     = cur_cmd.b;
    assign add_carry_in = cur_cmd.cin;

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_op_a, cmd_op_b, cmd_carry_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= S_IDLE;
            cur_cmd    <= '0;
            add_vld_in <= 1'b0;
            add_ex     <= 1'b0;
            add_op     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            ops_done   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + COUNT_W'(1);
            end else if (pop && !push) begin
                count <= count - COUNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        cur_cmd    <= fifo_mem[rd_ptr];
                        add_op     <= fifo_mem[rd_ptr].op;
                        add_vld_in <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    add_vld_in <= 1'b0;
                    add_ex     <= 1'b1;
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    add_ex <= 1'b0;
                    state  <= S_CAPT;
                end
                // The adder result registered on the EXEC edge is stable here.
                S_CAPT: begin
                    rsp_data  <= add_data_out;
                    rsp_carry <= add_carry_out;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        add_op    <= 1'b0;
                        ops_done  <= ops_done + CNT_WIDTH'(1);
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    add_vld_in <= 1'b0;
                    add_ex     <= 1'b0;
                    add_op     <= 1'b0;
                    rsp_valid  <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
